gaus_rand: RTL and testbench

GAUS_RAND -- requirements
Module: gaus_rand

---
 rtl/gaus_rand_pkg.sv | 39 +++
 rtl/gaus_rand_lfsr32_x8.sv | 38 +++
 rtl/gaus_rand.sv | 47 ++++
 tb/tb_gaus_rand.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gaus_rand_pkg.sv
// Shared constants and helpers for the Gaussian-approximate random source.
// Holds source count and widths, LFSR tap positions, the seed-spread constant,
// and functions for one LFSR step and per-source seed derivation.
package gaus_rand_pkg;

    localparam int unsigned NUM_SRC       = 16;
    localparam int unsigned LFSR_W        = 32;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned OUT_W         = 12;
    localparam int unsigned STEPS_PER_CLK = 8;

    // Taps of x^32 + x^22 + x^2 + x + 1 in Fibonacci form
    localparam int unsigned TAP_A = 31;
    localparam int unsigned TAP_B = 21;
    localparam int unsigned TAP_C = 1;
    localparam int unsigned TAP_D = 0;

    localparam logic [LFSR_W-1:0] SEED_SPREAD       = 32'h9E37_79B9;
    localparam logic [LFSR_W-1:0] SEED_BASE_DEFAULT = 32'hACE1_2468;

    // One Fibonacci shift: feedback enters at bit 0
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
        return {s[LFSR_W-2:0], fb};
    endfunction

    // Seed of source idx; the all-zero lock-up state is replaced by 1
    function automatic logic [LFSR_W-1:0] seed_of(input logic [LFSR_W-1:0] base,
                                                  input int unsigned       idx);
        logic [LFSR_W-1:0] s;
        s = base ^ (LFSR_W'(idx) * SEED_SPREAD);
        if (s == '0) begin
            s = LFSR_W'(1);
        end
        return s;
    endfunction

endpackage

// File: rtl/gaus_rand_lfsr32_x8.sv
// lfsr32_x8: single seeded 32-bit Fibonacci LFSR advancing 8 steps per clk.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset, loads SEED
//   rnd   - low byte of the registered LFSR state (8 fresh bits per cycle)
module lfsr32_x8
    import gaus_rand_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [BYTE_W-1:0] rnd
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_c;

    // Unrolled 8-step advance
    always_comb begin
        state_c = state_q;
        for (int unsigned k = 0; k < STEPS_PER_CLK; k++) begin
            state_c = lfsr_step(state_c);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_c;
        end
    end

    assign rnd = state_q[BYTE_W-1:0];

endmodule

// File: rtl/gaus_rand.sv
// gaus_rand: central-limit Gaussian approximation, sum of 16 uniform bytes.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset; gr clears and all LFSRs reseed
//   gr    - registered 12-bit unsigned sample (0..4080), new value every clk
module gaus_rand
    import gaus_rand_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_BASE = SEED_BASE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] gr
);

    logic [BYTE_W-1:0] src_byte [NUM_SRC];
    logic [OUT_W-1:0]  sum_c;

    // Sixteen independently seeded sources
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        lfsr32_x8 #(
            .SEED (seed_of(SEED_BASE, i))
        ) u_lfsr (
            .clk   (clk),
            .rst_n (rst_n),
            .rnd   (src_byte[i])
        );
    end

    // Adder tree; 12 bits holds 16*255 without loss
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            sum_c = sum_c + OUT_W'(src_byte[i]);
        end
    end

    // Output register: sums the LFSR bytes held before this edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gr <= '0;
        end else begin
            gr <= sum_c;
        end
    end

endmodule

// File: tb/tb_gaus_rand.sv
// Self-checking bench for gaus_rand: bit-accurate scoreboard model, reset
// behaviour, distribution statistics, mid-run reset replay and stall check.
module tb_gaus_rand;

    logic        clk;
    logic        rst_n;
    logic [11:0] gr;

    gaus_rand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gr    (gr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_state [16];
    logic [11:0] exp_q [$];
    logic [11:0] first_stream [0:2999];
    logic [11:0] last_gr;
    int          run_len;

    function automatic logic [31:0] tb_seed(input int i);
        logic [31:0] ii;
        logic [31:0] s;
        ii = 32'(i);
        s  = 32'hACE1_2468 ^ (ii * 32'h9E37_79B9);
        if (s == 32'h0) s = 32'h1;
        return s;
    endfunction

    function automatic logic [31:0] m_adv8(input logic [31:0] s);
        logic [31:0] t;
        logic        fb;
        t = s;
        for (int k = 0; k < 8; k++) begin
            fb = t[31] ^ t[21] ^ t[1] ^ t[0];
            t  = {t[30:0], fb};
        end
        return t;
    endfunction

    // Drive rst_n for one edge, push the expected gr, advance the model
    task automatic drive_cycle(input logic rst_val);
        int unsigned acc;
        rst_n = rst_val;
        if (!rst_val) begin
            exp_q.push_back(12'h000);
            for (int i = 0; i < 16; i++) m_state[i] = tb_seed(i);
        end else begin
            acc = 0;
            for (int i = 0; i < 16; i++) acc += int'(m_state[i][7:0]);
            exp_q.push_back(12'(acc));
            for (int i = 0; i < 16; i++) m_state[i] = m_adv8(m_state[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0);
            e = exp_q.pop_front();
            checks++;
            if (gr !== e || gr !== 12'h000) begin
                errors++;
                $display("FAIL reset_gr cycle=%0d got=%h want=%h", c, gr, 12'h000);
            end
        end
    endtask

    task automatic test_stream();
        logic [11:0] e;
        int unsigned seed_sum;
        real s, sq, mean, sd;
        int in_band;
        seed_sum = 0;
        for (int i = 0; i < 16; i++) seed_sum += int'(tb_seed(i) & 32'hFF);
        s = 0.0; sq = 0.0; in_band = 0;
        run_len = 0; last_gr = 12'hFFF;
        for (int c = 0; c < 10000; c++) begin
            drive_cycle(1'b1);
            e = exp_q.pop_front();
            checks++;
            if (gr !== e) begin
                errors++;
                $display("FAIL stream_model cycle=%0d got=%0d want=%0d", c, gr, e);
            end
            if (c == 0) begin
                checks++;
                if (gr !== 12'(seed_sum)) begin
                    errors++;
                    $display("FAIL first_sample got=%0d want=%0d", gr, seed_sum);
                end
            end
            checks++;
            if (gr > 12'd4080) begin
                errors++;
                $display("FAIL range cycle=%0d got=%0d want<=4080", c, gr);
            end
            if (c < 3000) first_stream[c] = gr;
            s  += real'(gr);
            sq += real'(gr) * real'(gr);
            if (gr >= 12'd1744 && gr <= 12'd2336) in_band++;
            if (gr == last_gr) run_len++; else run_len = 1;
            last_gr = gr;
        end
        mean = s / 10000.0;
        sd   = $sqrt(sq / 10000.0 - mean * mean);
        checks++;
        if (mean < 2030.0 || mean > 2050.0) begin
            errors++;
            $display("FAIL mean got=%f want=2040+/-10", mean);
        end
        checks++;
        if (sd < 286.0 || sd > 306.0) begin
            errors++;
            $display("FAIL stddev got=%f want=296+/-10", sd);
        end
        checks++;
        if (in_band < 6400 || in_band > 7200) begin
            errors++;
            $display("FAIL one_sigma_band got=%0d want=6400..7200 of 10000", in_band);
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] e;
        for (int c = 0; c < 5000; c++) begin
            drive_cycle(1'b1);
            e = exp_q.pop_front();
            checks++;
            if (gr !== e) begin
                errors++;
                $display("FAIL pre_reset_model cycle=%0d got=%0d want=%0d", c, gr, e);
            end
        end
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0);
            e = exp_q.pop_front();
            checks++;
            if (gr !== e || gr !== 12'h000) begin
                errors++;
                $display("FAIL mid_reset_gr cycle=%0d got=%h want=%h", c, gr, 12'h000);
            end
        end
        for (int c = 0; c < 3000; c++) begin
            drive_cycle(1'b1);
            e = exp_q.pop_front();
            checks++;
            if (gr !== first_stream[c] || gr !== e) begin
                errors++;
                $display("FAIL replay cycle=%0d got=%0d want=%0d", c, gr, first_stream[c]);
            end
        end
    endtask

    task automatic test_no_stall();
        logic [11:0] e;
        run_len = 0; last_gr = 12'hFFF;
        for (int c = 0; c < 20000; c++) begin
            drive_cycle(1'b1);
            e = exp_q.pop_front();
            checks++;
            if (gr !== e) begin
                errors++;
                $display("FAIL long_model cycle=%0d got=%0d want=%0d", c, gr, e);
            end
            if (gr == last_gr) run_len++; else run_len = 1;
            last_gr = gr;
            checks++;
            if (run_len >= 16) begin
                errors++;
                $display("FAIL stall cycle=%0d run=%0d want<16 value=%0d", c, run_len, gr);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_mid_reset();
        test_no_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
